rr_arbiter_chk: RTL and testbench
=================================

// Module: rr_arbiter_chk
// PURPOSE
//   N-channel round-robin request/grant arbiter with per-channel starvation monitor and hold limit.
//   Generalises the single req/gnt/en/ok contract to N channels: gnt never without req, en gates new grants,
//   ok reports fairness health. Sits between N requesters and one shared resource; formal-bench target.
// PARAMETERS
//   N         4    number of request channels (>=2)
//   HOLD_MAX  8    max consecutive grant cycles before forced release if others wait; 0 = unlimited
//   WAIT_MAX  16   wait cycles (req high, not granted) at which a channel counts as starved (>=1)
// PORTS
//   clk        in   1           clock, all state on posedge
//   rst        in   1           synchronous reset, active-high
//   en         in   1           arbitration enable; low = no new grants, current grant continues
//   req        in   N           request per channel, level; held high while resource is wanted
//   gnt        out  N           grant, one-hot or zero
//   gnt_valid  out  1           |gnt
//   gnt_id     out  $clog2(N)   index of owner; 0 when gnt_valid low
//   ok         out  1           registered health flag; low while any channel is starved
// BEHAVIOUR
//   Reset: state IDLE, owner 0, ptr 0, hold_cnt 0, all wait_cnt 0, ok=1; gnt/gnt_valid/gnt_id=0.
//   States: IDLE (no owner), BUSY (owner registered).
//   IDLE: at edge with en && |req -> BUSY, owner = first set req at/after ptr (rotating, wraps N-1->0).
//     Grant visible the cycle after the request is sampled (latency 1).
//   BUSY: gnt = onehot(owner) & req (combinational mask) -> gnt never high without its req.
//     Release when req[owner]==0 at edge, or hold_cnt==HOLD_MAX-1 (HOLD_MAX!=0) and another req pending.
//     On release: ptr = owner+1 mod N; if en && other req pending, re-grant at same edge (back-to-back,
//     no idle cycle), searching from new ptr, excluding released owner; else -> IDLE.
//     Forced release with no other requester: not taken; hold_cnt saturates at HOLD_MAX-1.
//   hold_cnt: cleared on every new grant, +1 per BUSY cycle.
//   en low in BUSY: owner kept until release, then -> IDLE; en only blocks new grants.
//   wait_cnt[i]: cleared when req[i]==0 or gnt[i]==1; else +1, saturating at WAIT_MAX.
//   ok <= !(any wait_cnt == WAIT_MAX) each edge; recovers 1 cycle after starved channel is served/drops.
//   Simultaneous: req[owner] drop + new reqs -> release and re-grant same edge; rst wins over everything.
//   Reset mid-grant: gnt=0 in cycle after rst sampled; arbitration restarts from ptr 0.
//   Widths: hold_cnt $clog2(HOLD_MAX+1) (min 1), wait_cnt $clog2(WAIT_MAX+1); no wrap, saturate only.
// CONFIGURATION
//   ARB_ASSERT_EN defined: embedded concurrent SVA on posedge clk, disable iff (rst):
//     A1 $onehot0(gnt); A2 gnt[i] |-> req[i]; A3 !gnt_valid && !en |=> !gnt_valid unless owner kept;
//     A4 gnt_valid && req[gnt_id] && hold_cnt<HOLD_MAX-1 |=> $stable(gnt_id);
//     A5 (HOLD_MAX!=0, en high) req[i] |-> no ok drop for WAIT_MAX>=N*HOLD_MAX+1; plus cover per-channel grant,
//     back-to-back grant, forced release.
//   Not defined: no assertions/covers compiled; RTL behaviour identical.
// STRUCTURE
//   Package arb_pkg: typedef enum logic {IDLE,BUSY} arb_state_t; function rr_next(req,ptr) helper;
//     localparam clog2 helper for widths.
//   Sub-module rr_pick: combinational rotating-priority picker (req, ptr, mask) -> found, idx.
//     Instantiated once; top holds FSM, counters, ok register, assertions.
// TESTING
//   rst=1 2 cycles, req=4'b1111 -> gnt=0, ok=1 throughout reset; after rst, en=1 -> gnt=0001 next cycle.
//   req=1111 held, HOLD_MAX=8 -> gnt rotates 0001,0010,0100,1000 every 8 cycles, no idle gap.
//   req=0001 only, en=1 -> gnt=0001 indefinitely (no forced release), ok stays 1.
//   owner 0 drops req while req=0100 -> gnt_id=2 at same edge, gnt_valid never 0.
//   en=0, req=0010 for 16 cycles -> gnt=0, ok=0 at cycle 17; en=1 -> grant, ok=1 two cycles later.
//   rst pulse during gnt=0100 -> gnt=0 next cycle; then with req=0101, first grant = 0001 (ptr 0).

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin arbiter: FSM state, counter widths, rotating search.
package arb_pkg;

  typedef enum logic {IDLE, BUSY} arb_state_t;

  // Widest request vector the rotating search handles.
  localparam int PICK_MAX = 32;

  // Bits needed to hold 0..max_val, never less than one.
  function automatic int width_for(input int max_val);
    int w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

  // First set bit of req at or after ptr, wrapping at n; -1 when req is empty.
  function automatic int rr_next(input logic [PICK_MAX-1:0] req, input int ptr, input int n);
    int         idx;
    logic [4:0] j;
    idx = -1;
    for (int k = PICK_MAX - 1; k >= 0; k--) begin
      if (k < n) begin
        j = 5'((ptr + k) % n);
        if (req[j]) idx = int'(j);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: lowest requester at or after ptr, ignoring masked channels.
module rr_pick
  import arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic [N-1:0]  mask,
  output logic          found,
  output logic [IW-1:0] idx
);

  logic [PICK_MAX-1:0] cand;
  int                  sel;

  always_comb begin
    cand          = '0;
    cand[N-1:0]   = req & ~mask;
    sel           = rr_next(cand, int'(ptr), N);
    found         = (sel >= 0);
    idx           = found ? IW'(sel) : '0;
  end

endmodule

// File: rtl/rr_arbiter_chk.sv
// N-channel round-robin arbiter with hold limit, per-channel starvation monitor and ok health flag.
// Optional embedded SVA checks and covers are compiled when ARB_ASSERT_EN is defined.
module rr_arbiter_chk
  import arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int HOLD_MAX = 8,
  parameter int WAIT_MAX = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         gnt,
  output logic                 gnt_valid,
  output logic [$clog2(N)-1:0] gnt_id,
  output logic                 ok
);

  localparam int IW = $clog2(N);
  localparam int HW = width_for(HOLD_MAX);
  localparam int WW = width_for(WAIT_MAX);
  // With HOLD_MAX == 0 the counter just parks at all-ones and never forces a release.
  localparam logic [HW-1:0] HOLD_SAT = (HOLD_MAX != 0) ? HW'(HOLD_MAX - 1) : {HW{1'b1}};
  localparam logic [WW-1:0] WAIT_SAT = WW'(WAIT_MAX);

  arb_state_t    state_reg, state_next;
  logic [IW-1:0] owner_reg, owner_next;
  logic [IW-1:0] ptr_reg, ptr_next;
  logic [HW-1:0] hold_cnt_reg, hold_cnt_next;
  logic          ok_reg;

  logic [N-1:0]  owner_oh;
  logic [IW-1:0] owner_inc;
  logic          busy, req_owner, others_pending, hold_limit, release_now;
  logic [IW-1:0] pick_ptr, pick_idx;
  logic [N-1:0]  pick_mask;
  logic          pick_found;
  logic [N-1:0]  starved;

  genvar gi;
  for (gi = 0; gi < N; gi++) begin : g_oh
    assign owner_oh[gi] = (owner_reg == IW'(gi));
  end

  assign owner_inc      = (owner_reg == IW'(N - 1)) ? '0 : owner_reg + 1'b1;
  assign busy           = (state_reg == BUSY);
  assign req_owner      = |(req & owner_oh);
  assign others_pending = |(req & ~owner_oh);
  assign hold_limit     = (HOLD_MAX != 0) && (hold_cnt_reg == HOLD_SAT);
  assign release_now    = busy && (!req_owner || (hold_limit && others_pending));

  // Masking with req keeps gnt low in the cycle an owner drops its request.
  assign gnt       = busy ? (owner_oh & req) : '0;
  assign gnt_valid = |gnt;
  assign gnt_id    = gnt_valid ? owner_reg : '0;
  assign ok        = ok_reg;

  // On release the search starts after the outgoing owner and skips it.
  assign pick_ptr  = busy ? owner_inc : ptr_reg;
  assign pick_mask = busy ? owner_oh : '0;

  rr_pick #(.N(N), .IW(IW)) u_pick (
    .req   (req),
    .ptr   (pick_ptr),
    .mask  (pick_mask),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    state_next    = state_reg;
    owner_next    = owner_reg;
    ptr_next      = ptr_reg;
    hold_cnt_next = hold_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (en && pick_found) begin
          state_next    = BUSY;
          owner_next    = pick_idx;
          hold_cnt_next = '0;
        end
      end
      BUSY: begin
        if (release_now) begin
          ptr_next      = owner_inc;
          hold_cnt_next = '0;
          if (en && pick_found) begin
            owner_next = pick_idx;
          end else begin
            state_next = IDLE;
          end
        end else if (hold_cnt_reg != HOLD_SAT) begin
          hold_cnt_next = hold_cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      owner_reg    <= '0;
      ptr_reg      <= '0;
      hold_cnt_reg <= '0;
      ok_reg       <= 1'b1;
    end else begin
      state_reg    <= state_next;
      owner_reg    <= owner_next;
      ptr_reg      <= ptr_next;
      hold_cnt_reg <= hold_cnt_next;
      ok_reg       <= ~|starved;
    end
  end

  for (gi = 0; gi < N; gi++) begin : g_wait
    logic [WW-1:0] wait_cnt_reg;
    always_ff @(posedge clk) begin
      if (rst || !req[gi] || gnt[gi]) begin
        wait_cnt_reg <= '0;
      end else if (wait_cnt_reg != WAIT_SAT) begin
        wait_cnt_reg <= wait_cnt_reg + 1'b1;
      end
    end
    assign starved[gi] = (wait_cnt_reg == WAIT_SAT);
  end

`ifdef ARB_ASSERT_EN
  a1_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));

  for (gi = 0; gi < N; gi++) begin : g_sva
    a2_gnt_req: assert property (@(posedge clk) disable iff (rst) gnt[gi] |-> req[gi]);
    c_grant:    cover property (@(posedge clk) disable iff (rst) gnt[gi]);
  end

  a3_en_block: assert property (@(posedge clk) disable iff (rst)
    !gnt_valid && !en |=> !gnt_valid);

  // Checked on owner_reg: the req mask may legitimately zero gnt_id in the next cycle.
  if (HOLD_MAX != 0) begin : g_hold_sva
    a4_stable: assert property (@(posedge clk) disable iff (rst)
      gnt_valid && req[gnt_id] && (hold_cnt_reg < HOLD_SAT) |=> $stable(owner_reg));
    c_forced: cover property (@(posedge clk) disable iff (rst)
      busy && req_owner && hold_limit && others_pending);
    if (WAIT_MAX >= N * HOLD_MAX + 1) begin : g_fair
      a5_no_starve: assert property (@(posedge clk) disable iff (rst)
        en [*(2 * WAIT_MAX)] |-> ok);
    end
  end

  c_b2b: cover property (@(posedge clk) disable iff (rst) release_now && en && pick_found);
`endif

endmodule

// File: tb/tb_rr_arbiter_chk.sv
// Self-checking bench for rr_arbiter_chk: vector table, directed corner sequences, random vs reference model.
module tb_rr_arbiter_chk;

  localparam int N        = 4;
  localparam int HOLD_MAX = 8;
  localparam int WAIT_MAX = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en  = 1'b0;
  logic [N-1:0] req = '0;
  logic [N-1:0] gnt;
  logic         gnt_valid;
  logic [1:0]   gnt_id;
  logic         ok;

  always #5 clk = ~clk;

  rr_arbiter_chk #(.N(N), .HOLD_MAX(HOLD_MAX), .WAIT_MAX(WAIT_MAX)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .req       (req),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id),
    .ok        (ok)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: owner -1 means nobody holds the resource.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_hold  = 0;
  int m_wait[N];
  bit m_ok    = 1'b1;

  typedef struct {
    logic         rst;
    logic         en;
    logic [N-1:0] req;
    logic [N-1:0] gnt;
    logic         ok;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit bit_of(input logic [N-1:0] v, input int i);
    logic [N-1:0] t;
    t = v >> i;
    return t[0];
  endfunction

  function automatic int find_req(input logic [N-1:0] r, input int from, input int excl);
    for (int k = 0; k < N; k++) begin
      int j;
      j = (from + k) % N;
      if (bit_of(r, j) && j != excl) return j;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_gnt(input logic [N-1:0] q);
    if (m_owner < 0) return '0;
    return q & (N'(1) << m_owner);
  endfunction

  task automatic model_edge(input logic r, input logic e, input logic [N-1:0] q);
    logic [N-1:0] served;
    if (r) begin
      m_owner = -1; m_ptr = 0; m_hold = 0; m_ok = 1'b1;
      for (int i = 0; i < N; i++) m_wait[i] = 0;
      return;
    end
    served = exp_gnt(q);
    m_ok = 1'b1;
    for (int i = 0; i < N; i++) if (m_wait[i] == WAIT_MAX) m_ok = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!bit_of(q, i) || bit_of(served, i)) m_wait[i] = 0;
      else if (m_wait[i] < WAIT_MAX) m_wait[i]++;
    end
    if (m_owner < 0) begin
      if (e) begin
        m_owner = find_req(q, m_ptr, -1);
        m_hold  = 0;
      end
    end else begin
      bit others, limit;
      others = (q & ~(N'(1) << m_owner)) != '0;
      limit  = (HOLD_MAX != 0) && (m_hold == HOLD_MAX - 1);
      if (!bit_of(q, m_owner) || (limit && others)) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = e ? find_req(q, m_ptr, m_owner) : -1;
        m_hold  = 0;
      end else if (m_hold < HOLD_MAX - 1) begin
        m_hold++;
      end
    end
  endtask

  task automatic check_model();
    logic [N-1:0] eg;
    eg = exp_gnt(req);
    chk("model_gnt", 32'(gnt), 32'(eg));
    chk("model_gnt_valid", 32'(gnt_valid), 32'(|eg));
    chk("model_gnt_id", 32'(gnt_id), (eg != '0) ? 32'(m_owner) : 32'd0);
    chk("model_ok", 32'(ok), 32'(m_ok));
  endtask

  task automatic step(input logic r, input logic e, input logic [N-1:0] q);
    @(negedge clk);
    rst = r; en = e; req = q;
    @(posedge clk);
    model_edge(r, e, q);
    #1;
    check_model();
  endtask

  initial begin
    logic [N-1:0] q;
    logic         e;

    tbl[0] = '{1'b1, 1'b0, 4'b1111, 4'b0000, 1'b1};
    tbl[1] = '{1'b1, 1'b1, 4'b1111, 4'b0000, 1'b1};
    tbl[2] = '{1'b0, 1'b1, 4'b1111, 4'b0001, 1'b1};
    tbl[3] = '{1'b0, 1'b1, 4'b1110, 4'b0010, 1'b1};
    tbl[4] = '{1'b0, 1'b0, 4'b0100, 4'b0000, 1'b1};
    tbl[5] = '{1'b0, 1'b1, 4'b0100, 4'b0100, 1'b1};
    tbl[6] = '{1'b1, 1'b1, 4'b0101, 4'b0000, 1'b1};
    tbl[7] = '{1'b0, 1'b1, 4'b0101, 4'b0001, 1'b1};
    tbl[8] = '{1'b0, 1'b1, 4'b0001, 4'b0001, 1'b1};
    tbl[9] = '{1'b0, 1'b1, 4'b0000, 4'b0000, 1'b1};

    for (int i = 0; i < 10; i++) begin
      step(tbl[i].rst, tbl[i].en, tbl[i].req);
      chk($sformatf("tbl%0d_gnt", i), 32'(gnt), 32'(tbl[i].gnt));
      chk($sformatf("tbl%0d_ok", i), 32'(ok), 32'(tbl[i].ok));
    end

    // Full load rotates every HOLD_MAX cycles with no idle gap.
    step(1'b1, 1'b0, '0);
    for (int c = 0; c < 4 * HOLD_MAX; c++) begin
      step(1'b0, 1'b1, 4'b1111);
      chk("rotate_gnt", 32'(gnt), 32'(1 << (c / HOLD_MAX)));
      chk("rotate_valid", 32'(gnt_valid), 32'd1);
    end

    // Lone requester is never forced off.
    step(1'b1, 1'b0, '0);
    for (int c = 0; c < 40; c++) begin
      step(1'b0, 1'b1, 4'b0001);
      chk("lone_gnt", 32'(gnt), 32'h1);
      chk("lone_ok", 32'(ok), 32'd1);
    end

    // Owner drops while channel 2 waits: handover at the same edge.
    step(1'b0, 1'b1, 4'b0100);
    chk("handover_id", 32'(gnt_id), 32'd2);
    chk("handover_valid", 32'(gnt_valid), 32'd1);

    // Starvation with en low, then recovery once served.
    step(1'b1, 1'b0, '0);
    for (int c = 1; c <= WAIT_MAX; c++) begin
      step(1'b0, 1'b0, 4'b0010);
      chk("starve_ok_high", 32'(ok), 32'd1);
    end
    step(1'b0, 1'b0, 4'b0010);
    chk("starve_ok_low", 32'(ok), 32'd0);
    step(1'b0, 1'b1, 4'b0010);
    chk("recover_gnt", 32'(gnt), 32'h2);
    chk("recover_ok_c1", 32'(ok), 32'd0);
    step(1'b0, 1'b1, 4'b0010);
    chk("recover_ok_c2", 32'(ok), 32'd0);
    step(1'b0, 1'b1, 4'b0010);
    chk("recover_ok_c3", 32'(ok), 32'd1);

    // Reset mid-grant, then arbitration restarts from channel 0.
    step(1'b0, 1'b1, 4'b0110);
    step(1'b1, 1'b1, 4'b0100);
    chk("rst_mid_gnt", 32'(gnt), 32'h0);
    step(1'b0, 1'b1, 4'b0101);
    chk("rst_restart_gnt", 32'(gnt), 32'h1);

    // Random traffic against the reference model, with periodic en-low windows.
    q = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) if ($urandom_range(0, 7) == 0) q[i] = ~q[i];
      e = ((c % 400) < 30) ? 1'b0 : ($urandom_range(0, 9) != 0);
      step(($urandom_range(0, 299) == 0), e, q);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
